io_sequencer: RTL and testbench
===============================

IO_SEQUENCER -- requirements
Module: io_sequencer

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of ir_data.
REQ-002 Parameter NUM_PORTS, default 4, range 1..16: number of I/O channels.
REQ-003 Parameter SEL_BITS, default 2: port-select width, equal to max(1, clog2(NUM_PORTS)).
REQ-004 Parameter TIMEOUT, default 255, range 1..65535: maximum wait cycles for a port handshake.
REQ-005 Parameter OP_IN, default 5'b10110, and parameter OP_OUT, default 5'b10111: I/O opcodes.
REQ-006 clk  input  1  single system clock; all state updates on the rising edge.
REQ-007 reset_n  input  1  asynchronous, active-low reset.
REQ-008 run  input  1  when high, the sequencer starts a new instruction from IDLE.
REQ-009 ir_data  input  DATA_WIDTH  current IR contents; opcode in [DATA_WIDTH-1:DATA_WIDTH-5], port number in [SEL_BITS-1:0].
REQ-010 port_valid  input  NUM_PORTS  per-port input-data-available flags.
REQ-011 port_ready  input  NUM_PORTS  per-port output-space-available flags.
REQ-012 PC_select, MAR_enable, PC_increment_enable, read, MDR_enable, MDR_select, IR_enable  output  1 each  fetch controls.
REQ-013 Gra, r_enable, r_select, inport_select, outport_enable  output  1 each  execute controls.
REQ-014 port_sel  output  SEL_BITS  port number captured at DECODE.
REQ-015 port_ack  output  NUM_PORTS  one-hot acknowledge to the selected port.
REQ-016 other_op  output  1  one-cycle pulse when a decoded opcode is neither OP_IN nor OP_OUT.
REQ-017 io_timeout  output  1  sticky error flag.
REQ-018 busy  output  1  high in every state except IDLE.

Function
REQ-019 States SHALL be IDLE, T0, T1, T2, DECODE, IN_WAIT, IN_WR, OUT_WAIT, OUT_WR. Outputs SHALL be Moore and decoded from the state register only.
REQ-020 IDLE -> T0 when run=1; otherwise remain in IDLE.
REQ-021 T0: PC_select=1 and MAR_enable=1 for 1 cycle, then T1.
REQ-022 T1: PC_increment_enable=1, read=1 and MDR_enable=1 for 1 cycle, then T2.
REQ-023 T2: MDR_select=1 and IR_enable=1 for 1 cycle, then DECODE.
REQ-024 DECODE: register port_sel=ir_data[SEL_BITS-1:0] and clear the wait counter.
  - opcode OP_IN -> IN_WAIT; opcode OP_OUT -> OUT_WAIT.
  - any other opcode -> other_op=1 for this cycle, then IDLE.
REQ-025 Port number >= NUM_PORTS in DECODE: treat as a timeout; set io_timeout and go to IDLE with no register or port write.
REQ-026 IN_WAIT: if port_valid[port_sel]=1, go to IN_WR; otherwise increment the counter. When the counter reaches TIMEOUT, set io_timeout and go to IDLE.
REQ-027 IN_WR, 1 cycle: Gra=1, r_enable=1, inport_select=1, port_ack[port_sel]=1; then IDLE.
REQ-028 OUT_WAIT: same rules as IN_WAIT, using port_ready[port_sel]; success goes to OUT_WR.
REQ-029 OUT_WR, 1 cycle: Gra=1, r_select=1, outport_enable=1, port_ack[port_sel]=1; then IDLE.
REQ-030 Latency with a port already valid/ready: 6 cycles from leaving IDLE to returning to IDLE (T0, T1, T2, DECODE, WAIT, WR).
REQ-031 A handshake seen in the same cycle the counter reaches TIMEOUT SHALL win: the transfer proceeds and io_timeout is not set.
REQ-032 The wait counter SHALL be 16 bits and SHALL saturate, never wrap.
REQ-033 port_ack SHALL be all zero outside IN_WR and OUT_WR, and at most one bit SHALL ever be high.
REQ-034 io_timeout stays set until reset_n is asserted; it does not block later instructions.
REQ-035 Changes on port_valid or port_ready outside the WAIT states SHALL have no effect.
REQ-036 run=1 at the return to IDLE starts the next fetch on the following cycle.

Reset
REQ-037 reset_n=0 SHALL immediately force state=IDLE, counter=0, port_sel=0 and io_timeout=0, without waiting for a clock edge.
REQ-038 While reset_n=0, every control output, port_ack, other_op and busy SHALL be 0.
REQ-039 Reset asserted mid-instruction SHALL abort the instruction with no further enables asserted.
REQ-040 After reset_n rises, the sequencer SHALL leave IDLE no earlier than the first rising edge of clk with run=1.

Verification
REQ-041 IN, port ready at once: ir_data opcode 10110, port 2, port_valid=4'b0100, run=1 -> T0..T2 strobes, then a single IN_WR cycle with Gra, r_enable, inport_select and port_ack=4'b0100; busy for exactly 6 cycles.
REQ-042 OUT with wait: opcode 10111, port 1, port_ready raised after 10 cycles in OUT_WAIT -> outport_enable, r_select and port_ack=4'b0010 for 1 cycle; io_timeout=0.
REQ-043 Timeout: TIMEOUT=8, opcode 10110, port_valid=0 -> io_timeout=1 after 8 wait cycles; no r_enable pulse; next instruction still runs.
REQ-044 Boundary: TIMEOUT=8, port_valid rises in the counter=8 cycle -> transfer completes and io_timeout=0.
REQ-045 Other opcode and bad port: opcode 00000 -> other_op pulse, then IDLE. NUM_PORTS=3 with port 3 -> io_timeout=1 and port_ack never asserted.
REQ-046 Reset during IN_WAIT: reset_n pulled low between clock edges -> outputs go to 0 immediately; after release, a fresh run restarts at T0.

Source files
------------

// File: rtl/io_sequencer.sv
// io_sequencer: fetch/decode/execute sequencer for IN and OUT port instructions.
// Walks T0..T2 fetch strobes, decodes the IR, then handshakes with the selected
// port under a bounded wait. All controls are decoded from registered state.
module io_sequencer #(
  parameter int         DATA_WIDTH = 32,
  parameter int         NUM_PORTS  = 4,
  parameter int         SEL_BITS   = 2,
  parameter int         TIMEOUT    = 255,
  parameter logic [4:0] OP_IN      = 5'b10110,
  parameter logic [4:0] OP_OUT     = 5'b10111
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  run,
  input  logic [DATA_WIDTH-1:0] ir_data,
  input  logic [NUM_PORTS-1:0]  port_valid,
  input  logic [NUM_PORTS-1:0]  port_ready,
  output logic                  PC_select,
  output logic                  MAR_enable,
  output logic                  PC_increment_enable,
  output logic                  read,
  output logic                  MDR_enable,
  output logic                  MDR_select,
  output logic                  IR_enable,
  output logic                  Gra,
  output logic                  r_enable,
  output logic                  r_select,
  output logic                  inport_select,
  output logic                  outport_enable,
  output logic [SEL_BITS-1:0]   port_sel,
  output logic [NUM_PORTS-1:0]  port_ack,
  output logic                  other_op,
  output logic                  io_timeout,
  output logic                  busy
);

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_DECODE, S_IN_WAIT, S_IN_WR, S_OUT_WAIT, S_OUT_WR
  } state_t;

  state_t                state_q, state_d;
  logic [15:0]           cnt_q, cnt_d;
  logic [SEL_BITS-1:0]   port_sel_q, port_sel_d;
  logic                  io_timeout_q, io_timeout_d;
  logic                  other_op_q, other_op_d;

  logic [4:0]            ir_op;
  logic [SEL_BITS-1:0]   ir_port;
  logic                  ir_port_ok;
  logic                  in_hs, out_hs;
  logic                  wait_expired;
  logic                  unused_ir_bits;

  assign ir_op          = ir_data[DATA_WIDTH-1 -: 5];
  assign ir_port        = ir_data[SEL_BITS-1:0];
  assign ir_port_ok     = 32'(ir_port) < 32'(NUM_PORTS);
  assign wait_expired   = cnt_q >= 16'(TIMEOUT);
  assign unused_ir_bits = ^ir_data[DATA_WIDTH-6:SEL_BITS];

  // Handshake flag of the latched port; a loop avoids indexing past NUM_PORTS.
  always_comb begin
    in_hs  = 1'b0;
    out_hs = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (port_sel_q == SEL_BITS'(i)) begin
        in_hs  = port_valid[i];
        out_hs = port_ready[i];
      end
    end
  end

  // Next-state logic; a handshake is checked before expiry so it wins ties.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    port_sel_d   = port_sel_q;
    io_timeout_d = io_timeout_q;
    other_op_d   = 1'b0;
    unique case (state_q)
      S_IDLE:   if (run) state_d = S_T0;
      S_T0:     state_d = S_T1;
      S_T1:     state_d = S_T2;
      S_T2:     state_d = S_DECODE;
      S_DECODE: begin
        port_sel_d = ir_port;
        cnt_d      = '0;
        if (ir_op == OP_IN || ir_op == OP_OUT) begin
          if (!ir_port_ok) begin
            io_timeout_d = 1'b1;
            state_d      = S_IDLE;
          end else begin
            state_d = (ir_op == OP_IN) ? S_IN_WAIT : S_OUT_WAIT;
          end
        end else begin
          other_op_d = 1'b1;
          state_d    = S_IDLE;
        end
      end
      S_IN_WAIT, S_OUT_WAIT: begin
        if ((state_q == S_IN_WAIT) ? in_hs : out_hs) begin
          state_d = (state_q == S_IN_WAIT) ? S_IN_WR : S_OUT_WR;
        end else if (wait_expired) begin
          io_timeout_d = 1'b1;
          state_d      = S_IDLE;
        end else if (cnt_q != 16'hFFFF) begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_IN_WR, S_OUT_WR: state_d = S_IDLE;
      default:           state_d = S_IDLE;
    endcase
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      port_sel_q   <= '0;
      io_timeout_q <= 1'b0;
      other_op_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      port_sel_q   <= port_sel_d;
      io_timeout_q <= io_timeout_d;
      other_op_q   <= other_op_d;
    end
  end

  // One-hot acknowledge only while a write state is held.
  always_comb begin
    port_ack = '0;
    if (state_q == S_IN_WR || state_q == S_OUT_WR) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        port_ack[i] = (port_sel_q == SEL_BITS'(i));
      end
    end
  end

  assign busy                = (state_q != S_IDLE);
  assign PC_select           = (state_q == S_T0);
  assign MAR_enable          = (state_q == S_T0);
  assign PC_increment_enable = (state_q == S_T1);
  assign read                = (state_q == S_T1);
  assign MDR_enable          = (state_q == S_T1);
  assign MDR_select          = (state_q == S_T2);
  assign IR_enable           = (state_q == S_T2);
  assign Gra                 = (state_q == S_IN_WR) || (state_q == S_OUT_WR);
  assign r_enable            = (state_q == S_IN_WR);
  assign inport_select       = (state_q == S_IN_WR);
  assign r_select            = (state_q == S_OUT_WR);
  assign outport_enable      = (state_q == S_OUT_WR);
  assign port_sel            = port_sel_q;
  assign other_op            = other_op_q;
  assign io_timeout          = io_timeout_q;

endmodule

// File: tb/tb_io_sequencer.sv
// tb_io_sequencer: drives two sequencers (4 ports/TIMEOUT 255 and 3 ports/TIMEOUT 8)
// from shared stimulus and compares every cycle against a cycle-offset model.
module tb_io_sequencer;
  localparam logic [4:0] OP_IN  = 5'b10110;
  localparam logic [4:0] OP_OUT = 5'b10111;
  localparam int NC = 28;

  logic        clk = 1'b0;
  logic        reset_n, run;
  logic [31:0] ir_data;
  logic [3:0]  pv, pr;

  logic a_pcs, a_mar, a_pci, a_rd, a_mdre, a_mdrs, a_ire, a_gra, a_ren, a_rsel, a_ins, a_oute;
  logic a_oth, a_to, a_busy;
  logic [1:0] a_sel;
  logic [3:0] a_ack;
  logic b_pcs, b_mar, b_pci, b_rd, b_mdre, b_mdrs, b_ire, b_gra, b_ren, b_rsel, b_ins, b_oute;
  logic b_oth, b_to, b_busy;
  logic [1:0] b_sel;
  logic [2:0] b_ack;

  int checks = 0;
  int errors = 0;
  logic       to_a = 1'b0, to_b = 1'b0;
  logic [1:0] sel_a = 2'd0, sel_b = 2'd0;

  always #5 clk = ~clk;

  io_sequencer #(.NUM_PORTS(4), .SEL_BITS(2), .TIMEOUT(255)) dut_a (
    .clk(clk), .reset_n(reset_n), .run(run), .ir_data(ir_data),
    .port_valid(pv), .port_ready(pr),
    .PC_select(a_pcs), .MAR_enable(a_mar), .PC_increment_enable(a_pci), .read(a_rd),
    .MDR_enable(a_mdre), .MDR_select(a_mdrs), .IR_enable(a_ire), .Gra(a_gra),
    .r_enable(a_ren), .r_select(a_rsel), .inport_select(a_ins), .outport_enable(a_oute),
    .port_sel(a_sel), .port_ack(a_ack), .other_op(a_oth), .io_timeout(a_to), .busy(a_busy));

  io_sequencer #(.NUM_PORTS(3), .SEL_BITS(2), .TIMEOUT(8)) dut_b (
    .clk(clk), .reset_n(reset_n), .run(run), .ir_data(ir_data),
    .port_valid(pv[2:0]), .port_ready(pr[2:0]),
    .PC_select(b_pcs), .MAR_enable(b_mar), .PC_increment_enable(b_pci), .read(b_rd),
    .MDR_enable(b_mdre), .MDR_select(b_mdrs), .IR_enable(b_ire), .Gra(b_gra),
    .r_enable(b_ren), .r_select(b_rsel), .inport_select(b_ins), .outport_enable(b_oute),
    .port_sel(b_sel), .port_ack(b_ack), .other_op(b_oth), .io_timeout(b_to), .busy(b_busy));

  wire [20:0] obs_a = {a_busy, a_pcs, a_mar, a_pci, a_rd, a_mdre, a_mdrs, a_ire, a_gra,
                       a_ren, a_rsel, a_ins, a_oute, a_oth, a_to, a_sel, a_ack};
  wire [20:0] obs_b = {b_busy, b_pcs, b_mar, b_pci, b_rd, b_mdre, b_mdrs, b_ire, b_gra,
                       b_ren, b_rsel, b_ins, b_oute, b_oth, b_to, b_sel, 1'b0, b_ack};

  // Expected outputs c cycles after the run edge, from the instruction's timing rules:
  // fetch at 0..2, decode at 3, wait from 4 for delay+1 cycles (at most tmo+1), then write.
  function automatic logic [20:0] model(input int c, input logic [4:0] op, input int port,
                                        input int delay, input int tmo, input int np,
                                        input logic to_prev, input logic [1:0] sel_prev);
    logic [20:0] e = '0;
    bit isin, io, bad;
    int blen = 4, wr_at = -1, to_at = -1;
    isin = (op == OP_IN);
    io   = isin || (op == OP_OUT);
    bad  = io && (port >= np);
    if (!io || bad) begin
      blen = 4;
      if (bad) to_at = 4;
    end else if (delay > tmo) begin
      blen  = 5 + tmo;
      to_at = blen;
    end else begin
      wr_at = 5 + delay;
      blen  = wr_at + 1;
    end
    e[20] = (c < blen);
    e[19] = (c == 0);
    e[18] = (c == 0);
    e[17] = (c == 1);
    e[16] = (c == 1);
    e[15] = (c == 1);
    e[14] = (c == 2);
    e[13] = (c == 2);
    if (c == wr_at) begin
      e[12] = 1'b1;
      if (isin) begin e[11] = 1'b1; e[9] = 1'b1; end
      else      begin e[10] = 1'b1; e[8] = 1'b1; end
      e[3:0] = 4'(1 << port);
    end
    e[7]   = !io && (c == 4);
    e[6]   = to_prev || (to_at >= 0 && c >= to_at);
    e[5:4] = (c >= 4) ? 2'(port) : sel_prev;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [20:0] obs, input logic [20:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one instruction and check both instances every cycle; abort_at>=0 stops early.
  task automatic run_instr(input logic [4:0] op, input int port, input int delay,
                           input int abort_at);
    logic [31:0] d;
    logic [3:0]  v;
    logic [20:0] ea, eb;
    d = {op, 27'($urandom)};
    d[1:0] = 2'(port);
    @(negedge clk);
    ir_data = d;
    run = 1'b1;
    pv = 4'($urandom);
    pr = 4'($urandom);
    for (int c = 0; c < NC; c++) begin
      @(negedge clk);
      run = 1'b0;
      ea = model(c, op, port, delay, 255, 4, to_a, sel_a);
      eb = model(c, op, port, delay, 8, 3, to_b, sel_b);
      chk($sformatf("A op=%b p=%0d d=%0d c=%0d", op, port, delay, c), obs_a, ea);
      chk($sformatf("B op=%b p=%0d d=%0d c=%0d", op, port, delay, c), obs_b, eb);
      if (c == abort_at) return;
      if (c >= 4) ir_data = $urandom;
      v = 4'($urandom);
      if (c >= 4 && c - 4 < delay) v[port] = 1'b0;
      else if (c >= 4 && c - 4 == delay) v[port] = 1'b1;
      if (op == OP_IN)       begin pv = v; pr = 4'($urandom); end
      else if (op == OP_OUT) begin pr = v; pv = 4'($urandom); end
      else                   begin pv = v; pr = 4'($urandom); end
      if (c == NC - 1) begin
        to_a = ea[6]; sel_a = ea[5:4];
        to_b = eb[6]; sel_b = eb[5:4];
      end
    end
  endtask

  initial begin
    logic [4:0] op;
    reset_n = 1'b0; run = 1'b0; ir_data = '0; pv = '0; pr = '0;
    repeat (2) @(negedge clk);
    chk("reset A", obs_a, 21'd0);
    chk("reset B", obs_b, 21'd0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("idle no run A", obs_a, 21'd0);
    chk("idle no run B", obs_b, 21'd0);

    run_instr(OP_IN,  2, 0,  -1);   // port already valid
    run_instr(OP_OUT, 1, 10, -1);   // ready after 10 wait cycles (B times out)
    run_instr(OP_IN,  1, 20, -1);   // B times out, A completes
    run_instr(OP_IN,  0, 8,  -1);   // handshake on the expiry cycle wins
    run_instr(OP_OUT, 2, 9,  -1);   // one cycle too late for B
    run_instr(5'b00000, 0, 0, -1);  // other opcode
    run_instr(OP_IN,  3, 0,  -1);   // port out of range for B

    for (int n = 0; n < 30; n++) begin
      case ($urandom_range(0, 4))
        0, 1:    op = OP_IN;
        2, 3:    op = OP_OUT;
        default: op = 5'($urandom);
      endcase
      run_instr(op, int'($urandom_range(0, 3)), int'($urandom_range(0, 12)), -1);
    end

    // Reset dropped mid-cycle while both instances wait on a port.
    run_instr(OP_IN, 0, 20, 6);
    #3 reset_n = 1'b0;
    #1;
    chk("async reset A", obs_a, 21'd0);
    chk("async reset B", obs_b, 21'd0);
    @(negedge clk);
    chk("held reset A", obs_a, 21'd0);
    chk("held reset B", obs_b, 21'd0);
    to_a = 1'b0; to_b = 1'b0; sel_a = 2'd0; sel_b = 2'd0;
    reset_n = 1'b1;
    @(negedge clk);
    chk("post reset idle A", obs_a, 21'd0);
    chk("post reset idle B", obs_b, 21'd0);
    run_instr(OP_IN, 0, 0, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
